// File: rtl/cory_int2_pkg.sv
// Shared constants and helpers for the cory_int2 interpolator.
// Optional feature macro: CORY_INT2_ROUND_EN selects round-half-up for the
// 2-tap mean. When it is undefined, the mean truncates.
package cory_int2_pkg;

    // Flag bits carried beside each sample through the output queue: {last, first}.
    localparam int FLAG_BITS = 2;

    // Rounding increment added to the (N+1)-bit sum before halving.
    function automatic logic round_bit();
`ifdef CORY_INT2_ROUND_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

endpackage

// File: rtl/cory_queue.sv
// cory_queue: valid/ready skid/FIFO stage of width W and depth D.
// D = 0 is a purely combinational pass-through; D > 0 is a D-entry FIFO whose
// input ready depends only on its fill level.
module cory_queue #(
    parameter int W = 8,
    parameter int D = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_a_v,
    input  logic [W-1:0] i_a_d,
    output logic         o_a_r,
    output logic         o_z_v,
    output logic [W-1:0] o_z_d,
    input  logic         i_z_r
);

    generate
        if (D == 0) begin : g_pass
            // No storage: clock and reset are not needed in this build.
            logic unused_ok;
            assign unused_ok = ^{clk, reset_n};
            assign o_z_v = i_a_v;
            assign o_z_d = i_a_d;
            assign o_a_r = i_z_r;
        end else begin : g_fifo
            localparam int AW = (D > 1) ? $clog2(D) : 1;
            localparam int CW = $clog2(D + 1);

            logic [W-1:0]  mem [D];
            logic [AW-1:0] wr_ptr_reg;
            logic [AW-1:0] rd_ptr_reg;
            logic [CW-1:0] count_reg;
            logic          push;
            logic          pop;

            assign o_a_r = (count_reg != CW'(D));
            assign o_z_v = (count_reg != '0);
            assign o_z_d = mem[rd_ptr_reg];
            assign push  = i_a_v && o_a_r;
            assign pop   = o_z_v && i_z_r;

            // Storage entries: each slot captures the input when the write pointer selects it.
            for (genvar gi = 0; gi < D; gi++) begin : g_slot
                always_ff @(posedge clk) begin
                    if (push && (wr_ptr_reg == AW'(gi))) begin
                        mem[gi] <= i_a_d;
                    end
                end
            end

            // Pointers and fill count; reset empties the queue.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= (wr_ptr_reg == AW'(D - 1)) ? '0 : wr_ptr_reg + AW'(1);
                    end
                    if (pop) begin
                        rd_ptr_reg <= (rd_ptr_reg == AW'(D - 1)) ? '0 : rd_ptr_reg + AW'(1);
                    end
                    if (push && !pop) begin
                        count_reg <= count_reg + CW'(1);
                    end else if (pop && !push) begin
                        count_reg <= count_reg - CW'(1);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/cory_int2.sv
// cory_int2: interpolate-by-2 with linear (2-tap mean) fill on a valid/ready
// stream. Each input x(k) produces x(k) followed by mean(x(k), x(k+1)); the
// last sample of a line is edge-replicated. Output passes through cory_queue.
// Optional feature macro: CORY_INT2_ROUND_EN (round-half-up mean; truncating
// mean when undefined).
module cory_int2
    import cory_int2_pkg::*;
#(
    parameter int N = 8,
    parameter int Q = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_a_v,
    input  logic [N-1:0] i_a_d,
    input  logic         i_a_first,
    input  logic         i_a_last,
    output logic         o_a_r,
    output logic         o_z_v,
    output logic [N-1:0] o_z_d,
    output logic         o_z_first,
    output logic         o_z_last,
    input  logic         i_z_r
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_EVEN  = 2'd1,
        S_HELD  = 2'd2,
        S_TAIL  = 2'd3
    } state_t;

    localparam int QW = N + FLAG_BITS;

    state_t       state_reg;
    state_t       state_next;
    logic [N-1:0] hold_reg;
    logic         f_first_reg;
    logic         f_last_reg;

    logic         load;
    logic         a_r;
    logic         int_v;
    logic [N-1:0] int_d;
    logic         int_first;
    logic         int_last;
    logic         int_r;

    logic         q_in_v;
    logic         q_out_v;
    logic [QW-1:0] q_out_d;

    // Mean of the held sample and the incoming one; the extra sum bit keeps
    // full-scale inputs from wrapping.
    logic [N:0]   sum;
    logic [N-1:0] mean;
    assign sum  = {1'b0, hold_reg} + {1'b0, i_a_d} + {{N{1'b0}}, round_bit()};
    assign mean = sum[N:1];

    // Next-state and internal-stream decode for the interpolation FSM.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        a_r        = 1'b0;
        int_v      = 1'b0;
        int_d      = hold_reg;
        int_first  = 1'b0;
        int_last   = 1'b0;
        case (state_reg)
            S_EMPTY: begin
                a_r = 1'b1;
                if (i_a_v) begin
                    load       = 1'b1;
                    state_next = S_EVEN;
                end
            end
            S_EVEN: begin
                int_v     = 1'b1;
                int_first = f_first_reg;
                if (int_r) begin
                    state_next = f_last_reg ? S_TAIL : S_HELD;
                end
            end
            S_HELD: begin
                if (!i_a_first) begin
                    // Odd beat is emitted in the same cycle the next sample is taken.
                    int_v = i_a_v;
                    int_d = mean;
                    a_r   = int_r;
                    if (i_a_v && int_r) begin
                        load       = 1'b1;
                        state_next = S_EVEN;
                    end
                end else begin
                    // A new line started without the old one ending: drop the held sample.
                    a_r = 1'b1;
                    if (i_a_v) begin
                        load       = 1'b1;
                        state_next = S_EVEN;
                    end
                end
            end
            S_TAIL: begin
                int_v    = 1'b1;
                int_last = 1'b1;
                if (int_r) begin
                    state_next = S_EMPTY;
                end
            end
            default: begin
                state_next = S_EMPTY;
            end
        endcase
    end

    // State register and held sample with its line flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= S_EMPTY;
            hold_reg    <= '0;
            f_first_reg <= 1'b0;
            f_last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                hold_reg    <= i_a_d;
                f_first_reg <= i_a_first;
                f_last_reg  <= i_a_last;
            end
        end
    end

    // Handshakes are suppressed while reset is held low.
    assign o_a_r  = a_r && reset_n;
    assign q_in_v = int_v && reset_n;
    assign o_z_v  = q_out_v && reset_n;

    cory_queue #(
        .W(QW),
        .D(Q)
    ) u_queue (
        .clk    (clk),
        .reset_n(reset_n),
        .i_a_v  (q_in_v),
        .i_a_d  ({int_last, int_first, int_d}),
        .o_a_r  (int_r),
        .o_z_v  (q_out_v),
        .o_z_d  (q_out_d),
        .i_z_r  (i_z_r)
    );

    assign o_z_d     = q_out_d[N-1:0];
    assign o_z_first = q_out_d[N];
    assign o_z_last  = q_out_d[N+1];

endmodule

// File: tb/tb_cory_int2.sv
// Self-checking bench for cory_int2 (N=8, Q=0). Expected beats are queued per
// line from a reference model and popped as the DUT transfers outputs.
module tb_cory_int2;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         i_a_v = 1'b0;
    logic [N-1:0] i_a_d = '0;
    logic         i_a_first = 1'b0;
    logic         i_a_last = 1'b0;
    logic         o_a_r;
    logic         o_z_v;
    logic [N-1:0] o_z_d;
    logic         o_z_first;
    logic         o_z_last;
    logic         i_z_r = 1'b1;

    cory_int2 #(.N(N), .Q(0)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_a_v    (i_a_v),
        .i_a_d    (i_a_d),
        .i_a_first(i_a_first),
        .i_a_last (i_a_last),
        .o_a_r    (o_a_r),
        .o_z_v    (o_z_v),
        .o_z_d    (o_z_d),
        .o_z_first(o_z_first),
        .o_z_last (o_z_last),
        .i_z_r    (i_z_r)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       first;
        logic       last;
        logic       noacc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic stall_mode = 1'b0;
    logic [5:0] stall_pat = 6'b101001;
    int   pat_idx = 0;
    int   cyc = 0;
    int   first_xfer = -1;
    int   last_xfer = -1;

    function automatic logic [7:0] mref(input int a, input int b);
        int s;
`ifdef CORY_INT2_ROUND_EN
        s = (a + b + 1) / 2;
`else
        s = (a + b) / 2;
`endif
        return s[7:0];
    endfunction

    function automatic exp_t mk(input int d, input bit f, input bit l, input bit n);
        exp_t e;
        e.d = d[7:0];
        e.first = f;
        e.last = l;
        e.noacc = n;
        return e;
    endfunction

    // Expected output beats for one line; a line without a last flag loses its odd tail.
    task automatic push_line(input int v[$], input bit has_last);
        int len;
        len = v.size();
        for (int k = 0; k < len; k++) begin
            exp_q.push_back(mk(v[k], k == 0, 1'b0, 1'b1));
            if (k < len - 1) begin
                exp_q.push_back(mk(mref(v[k], v[k + 1]), 1'b0, 1'b0, 1'b0));
            end else if (has_last) begin
                exp_q.push_back(mk(v[k], 1'b0, 1'b1, 1'b1));
            end
        end
    endtask

    // Output-ready driver: free-running or the 1,0,0,1,0,1 stall pattern.
    initial begin
        forever begin
            @(negedge clk);
            if (stall_mode) begin
                i_z_r = stall_pat[pat_idx];
                pat_idx = (pat_idx + 1) % 6;
            end else begin
                i_z_r = 1'b1;
            end
            cyc++;
        end
    end

    // Output monitor: scoreboard pop, stability while stalled, o_a_r during even/tail beats.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_d;
        logic       prev_f;
        logic       prev_l;
        exp_t       e;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_f = 1'b0;
        prev_l = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n) begin
                if (prev_stall) begin
                    vectors++;
                    if (o_z_v !== 1'b1 || o_z_d !== prev_d || o_z_first !== prev_f || o_z_last !== prev_l) begin
                        miscompares++;
                        $display("FAIL stall_hold: got v=%b d=%0d f=%b l=%b, required v=1 d=%0d f=%b l=%b",
                                 o_z_v, o_z_d, o_z_first, o_z_last, prev_d, prev_f, prev_l);
                    end
                end
                if (o_z_v && exp_q.size() > 0 && exp_q[0].noacc) begin
                    vectors++;
                    if (o_a_r !== 1'b0) begin
                        miscompares++;
                        $display("FAIL ready_in_even: got o_a_r=%b, required 0", o_a_r);
                    end
                end
                if (o_z_v && i_z_r) begin
                    vectors++;
                    if (first_xfer < 0) first_xfer = cyc;
                    last_xfer = cyc;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_beat: got d=%0d f=%b l=%b, required no output",
                                 o_z_d, o_z_first, o_z_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (o_z_d !== e.d || o_z_first !== e.first || o_z_last !== e.last) begin
                            miscompares++;
                            $display("FAIL beat: got d=%0d f=%b l=%b, required d=%0d f=%b l=%b",
                                     o_z_d, o_z_first, o_z_last, e.d, e.first, e.last);
                        end else begin
                            $display("beat d=%0d first=%b last=%b ok", o_z_d, o_z_first, o_z_last);
                        end
                    end
                end
                prev_stall = o_z_v && !i_z_r;
                prev_d = o_z_d;
                prev_f = o_z_first;
                prev_l = o_z_last;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Offer one sample and hold it until accepted, bounded.
    task automatic send_sample(input int d, input bit f, input bit l);
        bit done;
        done = 1'b0;
        @(negedge clk);
        i_a_v = 1'b1;
        i_a_d = d[7:0];
        i_a_first = f;
        i_a_last = l;
        for (int t = 0; t < 200 && !done; t++) begin
            #2;
            if (o_a_r) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got o_a_r=0 for 200 cycles, required accept of %0d", d);
        end
    endtask

    task automatic send_line(input int v[$], input bit has_last);
        for (int k = 0; k < v.size(); k++) begin
            send_sample(v[k], k == 0, has_last && (k == v.size() - 1));
        end
    endtask

    task automatic idle();
        @(negedge clk);
        i_a_v = 1'b0;
        i_a_first = 1'b0;
        i_a_last = 1'b0;
    endtask

    // Wait for all expected beats, then a few quiet cycles to catch extras.
    task automatic drain(input string name);
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) begin
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        vectors++;
        if (o_z_v !== 1'b0 || o_a_r !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got o_z_v=%b o_a_r=%b, required 0 0", o_z_v, o_a_r);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        vectors++;
        if (o_z_v !== 1'b0 || o_a_r !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: got o_z_v=%b o_a_r=%b, required 0 1", o_z_v, o_a_r);
        end
    endtask

    task automatic test_basic();
        int v[$];
        v = {10, 20, 30};
        push_line(v, 1'b1);
        send_line(v, 1'b1);
        idle();
        drain("basic");
    endtask

    task automatic test_rounding();
        int v[$];
        v = {3, 4};
        push_line(v, 1'b1);
        send_line(v, 1'b1);
        idle();
        drain("round");
        v = {255, 255};
        push_line(v, 1'b1);
        send_line(v, 1'b1);
        idle();
        drain("fullscale");
    endtask

    task automatic test_single();
        int v[$];
        v = {200};
        push_line(v, 1'b1);
        send_line(v, 1'b1);
        idle();
        drain("single");
    endtask

    task automatic test_stall();
        int v[$];
        stall_mode = 1'b1;
        pat_idx = 0;
        v = {10, 20, 30};
        push_line(v, 1'b1);
        send_line(v, 1'b1);
        idle();
        drain("stall");
        stall_mode = 1'b0;
    endtask

    task automatic test_missing_last();
        int v[$];
        v = {1, 2};
        push_line(v, 1'b0);
        v = {50, 60};
        push_line(v, 1'b1);
        v = {1, 2};
        send_line(v, 1'b0);
        v = {50, 60};
        send_line(v, 1'b1);
        idle();
        drain("nolast");
    endtask

    task automatic test_back_to_back();
        int v[$];
        v = {5, 9, 13, 17, 21};
        push_line(v, 1'b1);
        first_xfer = -1;
        send_line(v, 1'b1);
        idle();
        drain("throughput");
        vectors++;
        if (last_xfer - first_xfer != 9) begin
            miscompares++;
            $display("FAIL throughput: got %0d cycles for 10 beats, required 9", last_xfer - first_xfer);
        end
        v = {100, 0};
        push_line(v, 1'b1);
        v = {7, 8, 9};
        push_line(v, 1'b1);
        v = {100, 0};
        send_line(v, 1'b1);
        v = {7, 8, 9};
        send_line(v, 1'b1);
        idle();
        drain("b2b");
    endtask

    task automatic test_reset_midline();
        int v[$];
        v = {10, 20};
        exp_q.push_back(mk(10, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(mk(mref(10, 20), 1'b0, 1'b0, 1'b0));
        send_line(v, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        i_a_v = 1'b0;
        i_a_first = 1'b0;
        #2;
        vectors++;
        if (o_z_v !== 1'b0 || o_a_r !== 1'b0) begin
            miscompares++;
            $display("FAIL midline_reset: got o_z_v=%b o_a_r=%b, required 0 0", o_z_v, o_a_r);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL midline_pre: got %0d beats outstanding, required 0", exp_q.size());
        end
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        vectors++;
        if (o_z_v !== 1'b0 || o_a_r !== 1'b1) begin
            miscompares++;
            $display("FAIL midline_after: got o_z_v=%b o_a_r=%b, required 0 1", o_z_v, o_a_r);
        end
        repeat (3) @(negedge clk);
        v = {7, 7};
        push_line(v, 1'b1);
        send_line(v, 1'b1);
        idle();
        drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_single();
        test_stall();
        test_missing_last();
        test_back_to_back();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
